// File: rtl/rot8_pkg.sv
// Shared types and constants for the 8-bit rotate issue stage.
package rot8_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
        logic              left;
    } rot8_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } rot8_state_t;

endpackage

// File: rtl/rot8_cmd_fifo.sv
// Circular command buffer for the rotate issue stage; DEPTH must be a power of two.
module rot8_cmd_fifo
    import rot8_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  rot8_cmd_t              push_cmd,
    input  logic                   pop,
    output rot8_cmd_t              pop_cmd,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rot8_cmd_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_cmd = mem[rd_ptr];

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_cmd;
    end

endmodule

// File: rtl/rot8_issue_stage.sv
// Buffers rotate commands, drives an external combinational rotator and holds each result
// until accepted. Optional res_parity output is enabled by defining ROT8_PARITY_EN.
module rot8_issue_stage
    import rot8_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_left,
    output logic [DATA_W-1:0] rot_data,
    output logic [SEL_W-1:0]  rot_sel,
    output logic              rot_left,
    input  logic [DATA_W-1:0] rot_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [SEL_W-1:0]  res_sel,
    output logic              res_left
`ifdef ROT8_PARITY_EN
    ,
    output logic              res_parity
`endif
);

    rot8_state_t                 state;
    rot8_cmd_t                   in_cmd;
    rot8_cmd_t                   head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        push;
    logic                        pop;

    assign in_cmd   = '{data: in_data, sel: in_sel, left: in_left};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !rst;
    // The head is taken from IDLE, or from HOLD on the same edge the result is accepted.
    assign pop      = !rst && !fifo_empty &&
                      ((state == IDLE) || ((state == HOLD) && res_ready));

    rot8_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_cmd(in_cmd),
        .pop     (pop),
        .pop_cmd (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rot_data  <= '0;
            rot_sel   <= '0;
            rot_left  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
            res_left  <= 1'b0;
`ifdef ROT8_PARITY_EN
            res_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        rot_data <= head.data;
                        rot_sel  <= head.sel;
                        rot_left <= head.left;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_data  <= rot_out;
                    res_sel   <= rot_sel;
                    res_left  <= rot_left;
                    res_valid <= 1'b1;
`ifdef ROT8_PARITY_EN
                    res_parity <= ^rot_out;
`endif
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            rot_data <= head.data;
                            rot_sel  <= head.sel;
                            rot_left <= head.left;
                            state    <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_empty == (fifo_count == '0));
        end
    end

endmodule
